serial_capture_mem: RTL
=======================

Name: serial_capture_mem

Overview:
Serial-to-parallel capture block: the receive-side counterpart of the waveform generator that serialises a 16x8 pattern memory LSB-first through an 8:1 bit mux.
- Accepts a 1-bit stream, reassembles 8-bit words LSB-first and writes them into a 16-entry x 8-bit internal memory at incrementing addresses.
- Stored words are readable through an asynchronous read port.
- Sits at the far end of the pattern-generator link as a capture buffer for loopback checking.

Parameters:
WORD_W, 8, bits per word; bit index 0 is received first
DEPTH, 16, number of memory words
ADDR_W, 4, address width, equal to log2(DEPTH)

Ports:
clock  input  1  system clock, all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a capture at address 0
circular  input  1  sampled at start; 1 = wrap to address 0 and keep capturing, 0 = stop after word DEPTH-1
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is accepted on this edge when high and state is CAPTURE
rd_addr  input  ADDR_W  read address
rd_data  output  WORD_W  mem[rd_addr], combinational read
busy  output  1  high while in CAPTURE
done  output  1  high in DONE, held until next start or reset
word_wr  output  1  one-cycle pulse after each completed word write
wr_addr  output  ADDR_W  address of the word written most recently
mismatch_cnt  output  ADDR_W+1  pattern-check error count (see Optional Feature)

Behaviour:
- Reset, synchronous and active-high. Clears:
  - state to IDLE; bit_cnt, word_addr, shift register, busy, done, word_wr, wr_addr, mismatch_cnt to 0; stored circular flag to 0.
  - Memory contents are NOT cleared.
  - Reset mid-word discards the partial word; no write occurs.
- States and transitions:
  - IDLE: start=1 -> CAPTURE; load circular flag, bit_cnt=0, word_addr=0, mismatch_cnt=0.
  - CAPTURE: on each edge with in_valid=1, store in_bit at shift[bit_cnt] and increment bit_cnt. in_valid=0 holds all state; gaps of any length are legal.
  - Accepting the bit with bit_cnt==WORD_W-1:
    - write {in_bit, shift[WORD_W-2:0]} to mem[word_addr] on that same edge;
    - word_wr=1 and wr_addr=word_addr in the next cycle;
    - bit_cnt wraps to 0.
  - After that write, word_addr==DEPTH-1:
    - circular=0: -> DONE, done=1 the next cycle, busy=0.
    - circular=1: word_addr wraps to 0, stay in CAPTURE.
    - Otherwise word_addr increments.
  - start while in CAPTURE is ignored, with no restart.
  - DONE: start=1 -> CAPTURE with the same initialisation as from IDLE, and done drops the next cycle.
- Timing:
  - busy rises in the cycle after start.
  - Without gaps, a full non-circular capture takes WORD_W*DEPTH = 128 accepted bits, and done rises 1 cycle after the last accepted bit.
- Read port:
  - rd_data reflects memory after the most recent edge.
  - A read of the address being written returns the new word from the cycle after the write edge.
- in_valid outside CAPTURE is ignored.

Optional Feature:
Macro SERIAL_CAPTURE_PATTERN_CHECK_EN.
- Defined: each written word is compared with the expected generator pattern: 8'hCC at even addresses, 8'hAA at odd addresses.
  - Each mismatch increments mismatch_cnt in the same cycle word_wr pulses.
  - The counter saturates at all ones and is cleared on start and on reset.
- Undefined: mismatch_cnt is tied to 0 and no compare logic is built.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, CAPTURE=1, DONE=2);
  - WORD_W / DEPTH / ADDR_W defaults;
  - expected-pattern constants PAT_EVEN=8'hCC and PAT_ODD=8'hAA, also used by the generator bench.
- One natural sub-module: capture_deser, holding shift register, bit counter and word-complete strobe. The top holds the FSM, address counter, memory and checker.

Test Plan:
1. Reset, start, circular=0; stream 8'hCC/8'hAA alternating LSB-first (CC = 0,0,1,1,0,0,1,1), in_valid constant -> 16 word_wr pulses; done=1 one cycle after bit 128; mem[0]=CC, mem[1]=AA, mem[15]=AA; mismatch_cnt=0.
2. Same stream with in_valid low every third cycle -> identical memory contents; done rises 1 cycle after the 128th accepted bit; busy holds throughout.
3. circular=1; send 136 bits where word 16 is 8'h3C -> mem[0]=3C, wr_addr=0 on that pulse, done stays 0, busy stays 1.
4. Assert reset after 4 bits of word 5; then start and send 8 bits of 8'h5A -> state IDLE after reset with no write; after restart mem[0]=5A and mem[1..15] retain old values.
5. Assert start at bit 20 of a capture -> ignored; word_addr continues; final done at bit 128 as normal.
6. With SERIAL_CAPTURE_PATTERN_CHECK_EN, send the pattern with word 3 = 8'h55 -> mismatch_cnt=1 after the pulse for address 3 and stays 1 at done; without the macro, mismatch_cnt=0.

Source files
------------

// File: rtl/serial_capture_mem_pkg.sv
// Shared definitions for the serial capture memory and the pattern
// generator bench that feeds it.
//   - state_t          : capture FSM encoding (IDLE=0, CAPTURE=1, DONE=2)
//   - *_DEF            : default word width, memory depth and address width
//   - PAT_EVEN/PAT_ODD : expected generator words at even / odd addresses
//   - expected_pattern : selects the expected word from an address LSB
package serial_capture_mem_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    localparam logic [7:0] PAT_EVEN = 8'hCC;
    localparam logic [7:0] PAT_ODD  = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic logic [7:0] expected_pattern(input logic addr_lsb);
        return addr_lsb ? PAT_ODD : PAT_EVEN;
    endfunction

endpackage

// File: rtl/serial_capture_mem_capture_deser.sv
// capture_deser: LSB-first serial-to-parallel converter.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   clear         : restarts word assembly at bit 0 (new capture)
//   shift_en      : in_bit is accepted on this edge
//   in_bit        : serial data
//   word_complete : combinational strobe, high while the last bit of a word
//                   is being accepted
//   word          : assembled word including the bit being accepted, valid
//                   while word_complete is high
module capture_deser #(
    parameter int WORD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              in_bit,
    output logic              word_complete,
    output logic [WORD_W-1:0] word
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [CNT_W-1:0]  bit_cnt_reg;
    // The top bit never needs storing: it is taken straight from in_bit
    // on the edge that completes the word.
    logic [WORD_W-2:0] shift_reg;

    assign word_complete = shift_en && (bit_cnt_reg == CNT_W'(WORD_W - 1));
    assign word          = {in_bit, shift_reg};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            bit_cnt_reg <= word_complete ? '0 : bit_cnt_reg + 1'b1;
        end
    end

    // Each stored bit loads only when the counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    shift_reg[gi] <= 1'b0;
                end else if (shift_en && (bit_cnt_reg == CNT_W'(gi))) begin
                    shift_reg[gi] <= in_bit;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/serial_capture_mem.sv
// serial_capture_mem: captures an LSB-first bit stream into a DEPTH x WORD_W
// memory at incrementing addresses, one-shot or circular.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : begin a capture at address 0 (ignored while capturing)
//   circular      : sampled with start; 1 = wrap and keep capturing
//   in_bit/in_valid : serial data and its qualifier
//   rd_addr/rd_data : asynchronous read port
//   busy, done    : capture in progress / one-shot capture finished
//   word_wr, wr_addr : one-cycle pulse and address of the last word written
//   mismatch_cnt  : saturating count of words differing from the generator
//                   pattern; built only when SERIAL_CAPTURE_PATTERN_CHECK_EN
//                   is defined, otherwise tied to 0
module serial_capture_mem
    import serial_capture_mem_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              circular,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              word_wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   mismatch_cnt
);

    state_t            state_reg;
    logic              circular_reg;
    logic [ADDR_W-1:0] word_addr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              word_wr_reg;
    logic [ADDR_W-1:0] wr_addr_reg;

    logic              start_accept;
    logic              shift_en;
    logic              word_complete;
    logic [WORD_W-1:0] word_data;

    logic [WORD_W-1:0] mem [DEPTH];

    // A start only counts outside CAPTURE; a running capture is never restarted.
    assign start_accept = start && (state_reg != ST_CAPTURE);
    assign shift_en     = in_valid && (state_reg == ST_CAPTURE);

    capture_deser #(.WORD_W(WORD_W)) u_deser (
        .clock         (clock),
        .reset         (reset),
        .clear         (start_accept),
        .shift_en      (shift_en),
        .in_bit        (in_bit),
        .word_complete (word_complete),
        .word          (word_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            circular_reg  <= 1'b0;
            word_addr_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            word_wr_reg   <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            word_wr_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg     <= ST_CAPTURE;
                        circular_reg  <= circular;
                        word_addr_reg <= '0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (word_complete) begin
                        word_wr_reg <= 1'b1;
                        wr_addr_reg <= word_addr_reg;
                        if (word_addr_reg == ADDR_W'(DEPTH - 1)) begin
                            word_addr_reg <= '0;
                            if (!circular_reg) begin
                                state_reg <= ST_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            word_addr_reg <= word_addr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Memory is not reset; a reset on the completing edge suppresses the write
    // so a reset always discards the word in flight.
    always_ff @(posedge clock) begin
        if (word_complete && !reset) begin
            mem[word_addr_reg] <= word_data;
        end
    end

    assign rd_data = mem[rd_addr];

`ifdef SERIAL_CAPTURE_PATTERN_CHECK_EN
    logic [ADDR_W:0] mismatch_cnt_reg;

    // Updated on the write edge so the new count appears with word_wr.
    always_ff @(posedge clock) begin
        if (reset || start_accept) begin
            mismatch_cnt_reg <= '0;
        end else if (word_complete
                     && (word_data != WORD_W'(expected_pattern(word_addr_reg[0])))
                     && (mismatch_cnt_reg != '1)) begin
            mismatch_cnt_reg <= mismatch_cnt_reg + 1'b1;
        end
    end

    assign mismatch_cnt = mismatch_cnt_reg;
`else
    assign mismatch_cnt = '0;
`endif

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign word_wr = word_wr_reg;
    assign wr_addr = wr_addr_reg;

endmodule
